fm_mix_seq: RTL

Parametrised slot sequencer and stereo mixer for the FM audio path. It generates the sample tick and steps an external operator pipeline through NUM_SLOTS time-multiplexed slots. It accumulates each summed slot result into left/right accumulators, then applies master volume, saturates, and registers the stereo output. It also stalls bus writes while a sample is being computed.

---
 rtl/fm_mix_seq_if.sv | 51 +++++
 rtl/fm_mix_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_mix_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fm_mix_seq_if
// Description : Bus-stall and operator-pipeline slot signals shared between
//               the FM slot sequencer/mixer (master) and the operator
//               pipeline / register bus (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fm_mix_seq_if #(
    parameter int NUM_SLOTS = 64,
    parameter int RES_W     = 13
);
    localparam int SLOT_BITS = $clog2(NUM_SLOTS);

    logic                        bus_wren;
    logic                        bus_wait;
    logic [SLOT_BITS-1:0]        slot_sel;
    logic                        slot_next;
    logic                        op_reset;
    logic signed [RES_W-1:0]     slot_result;
    logic                        slot_sum;
    logic                        slot_left;
    logic                        slot_right;

    // Sequencer side: drives slot stepping and the bus stall
    modport master (
        input  bus_wren,
        output bus_wait,
        output slot_sel,
        output slot_next,
        output op_reset,
        input  slot_result,
        input  slot_sum,
        input  slot_left,
        input  slot_right
    );

    // Pipeline / bus side
    modport slave (
        output bus_wren,
        input  bus_wait,
        input  slot_sel,
        input  slot_next,
        input  op_reset,
        output slot_result,
        output slot_sum,
        output slot_left,
        output slot_right
    );
endinterface
`default_nettype wire

// File: rtl/fm_mix_seq.sv
`default_nettype none
// ============================================================================
// Module      : fm_mix_seq
// Description : FM slot sequencer and stereo mixer. Generates the sample tick,
//               steps the operator pipeline through NUM_SLOTS slots,
//               accumulates routed slot results, applies master volume with
//               saturation and registers the stereo sample.
//               Optional macro MIX_PEAK_EN adds per-channel peak-hold meters.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_mix_seq #(
    parameter int NUM_SLOTS  = 64,
    parameter int RES_W      = 13,
    parameter int OUT_W      = 16,
    parameter int SAMPLE_DIV = 506
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    fm_mix_seq_if.master                  bus,
    input  wire logic [7:0]               master_vol,
    output logic signed [OUT_W-1:0]       audio_l,
    output logic signed [OUT_W-1:0]       audio_r,
    output logic                          sample_valid,
    output logic                          overrun,
    output logic [OUT_W-1:0]              peak_l,
    output logic [OUT_W-1:0]              peak_r,
    input  wire logic                     peak_clr
);
    localparam int SLOT_BITS = $clog2(NUM_SLOTS);
    localparam int ACC_W     = RES_W + SLOT_BITS;
    localparam int PROD_W    = ACC_W + 9;
    localparam int CNT_W     = $clog2(SAMPLE_DIV);

    localparam logic [CNT_W-1:0]     c_cnt_last  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [SLOT_BITS-1:0] c_last_slot = SLOT_BITS'(NUM_SLOTS - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_start   = 3'd1;
    localparam logic [2:0] c_st_process = 3'd2;
    localparam logic [2:0] c_st_next    = 3'd3;
    localparam logic [2:0] c_st_finish  = 3'd4;

    logic [2:0]               r_state;
    logic [2:0]               w_state_next;
    logic [CNT_W-1:0]         r_tick_cnt;
    logic                     r_tick;
    logic [SLOT_BITS-1:0]     r_slot_sel;
    logic                     r_slot_next;
    logic                     r_op_reset;
    logic                     r_overrun;
    logic signed [ACC_W-1:0]  r_acc_l;
    logic signed [ACC_W-1:0]  r_acc_r;
    logic signed [OUT_W-1:0]  r_audio_l;
    logic signed [OUT_W-1:0]  r_audio_r;
    logic                     r_sample_valid;

    logic                     w_last_slot;
    logic                     w_acc_add_l;
    logic                     w_acc_add_r;
    logic                     w_slot_clr;
    logic                     w_slot_inc;
    logic                     w_finish;
    logic signed [ACC_W-1:0]  w_res_ext;
    logic signed [PROD_W-1:0] w_acc_l_x;
    logic signed [PROD_W-1:0] w_acc_r_x;
    logic signed [PROD_W-1:0] w_vol_x;
    logic signed [PROD_W-1:0] w_prod_l;
    logic signed [PROD_W-1:0] w_prod_r;
    logic signed [PROD_W-1:0] w_shift_l;
    logic signed [PROD_W-1:0] w_shift_r;

    // Clamp a scaled sum into the signed output range. The value fits when
    // every bit from the output sign bit upward is a copy of the sign.
    function automatic logic [OUT_W-1:0] f_sat(input logic [PROD_W-1:0] s);
        logic [PROD_W-OUT_W:0] v_top;
        v_top = s[PROD_W-1:OUT_W-1];
        if ((&v_top) || !(|v_top)) begin
            return s[OUT_W-1:0];
        end else if (s[PROD_W-1]) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    assign w_last_slot  = (r_slot_sel == c_last_slot);
    assign w_res_ext    = {{SLOT_BITS{bus.slot_result[RES_W-1]}}, bus.slot_result};

    // Volume is an unsigned gain, so it is zero-extended; accumulators are
    // sign-extended so the product is exact in PROD_W bits.
    assign w_acc_l_x    = {{(PROD_W-ACC_W){r_acc_l[ACC_W-1]}}, r_acc_l};
    assign w_acc_r_x    = {{(PROD_W-ACC_W){r_acc_r[ACC_W-1]}}, r_acc_r};
    assign w_vol_x      = {{(PROD_W-8){1'b0}}, master_vol};
    assign w_prod_l     = w_acc_l_x * w_vol_x;
    assign w_prod_r     = w_acc_r_x * w_vol_x;
    assign w_shift_l    = w_prod_l >>> 7;
    assign w_shift_r    = w_prod_r >>> 7;

    // Bus writes are held off for the whole sample computation
    assign bus.bus_wait = bus.bus_wren && (r_state != c_st_idle);
    assign bus.slot_sel = r_slot_sel;
    assign bus.slot_next = r_slot_next;
    assign bus.op_reset = r_op_reset;

    assign audio_l      = r_audio_l;
    assign audio_r      = r_audio_r;
    assign sample_valid = r_sample_valid;
    assign overrun      = r_overrun;

    // Free-running sample-rate divider producing a one-cycle tick on wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= (r_tick_cnt == c_cnt_last);
            if (r_tick_cnt == c_cnt_last) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: one PROCESS/NEXT pair per slot, ticks only start from IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:    if (r_tick) w_state_next = c_st_start;
            c_st_start:   w_state_next = c_st_process;
            c_st_process: w_state_next = c_st_next;
            c_st_next:    w_state_next = w_last_slot ? c_st_finish : c_st_process;
            c_st_finish:  w_state_next = c_st_idle;
            default:      w_state_next = c_st_idle;
        endcase
    end

    // FSM outputs: per-state datapath enables
    always_comb begin
        w_acc_add_l = 1'b0;
        w_acc_add_r = 1'b0;
        w_slot_clr  = 1'b0;
        w_slot_inc  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            c_st_start: begin
                w_slot_clr = 1'b1;
            end
            c_st_process: begin
                w_acc_add_l = !r_op_reset && bus.slot_sum && bus.slot_left;
                w_acc_add_r = !r_op_reset && bus.slot_sum && bus.slot_right;
            end
            c_st_next: begin
                w_slot_inc = !w_last_slot;
            end
            c_st_finish: begin
                w_finish = 1'b1;
            end
            default: begin
                w_finish = 1'b0;
            end
        endcase
    end

    // Slot stepping, accumulation, output scaling and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_sel     <= '0;
            r_slot_next    <= 1'b0;
            r_op_reset     <= 1'b1;
            r_overrun      <= 1'b0;
            r_acc_l        <= '0;
            r_acc_r        <= '0;
            r_audio_l      <= '0;
            r_audio_r      <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_slot_next    <= (r_state == c_st_process);
            r_sample_valid <= w_finish;

            if (w_slot_clr) begin
                r_slot_sel <= '0;
            end else if (w_slot_inc) begin
                r_slot_sel <= r_slot_sel + SLOT_BITS'(1);
            end

            // A tick that lands mid-sample is dropped and only flagged
            if (r_tick && (r_state != c_st_idle)) begin
                r_overrun <= 1'b1;
            end

            if (w_finish) begin
                r_audio_l  <= f_sat(w_shift_l);
                r_audio_r  <= f_sat(w_shift_r);
                r_acc_l    <= '0;
                r_acc_r    <= '0;
                r_op_reset <= 1'b0;
            end else begin
                if (w_acc_add_l) r_acc_l <= r_acc_l + w_res_ext;
                if (w_acc_add_r) r_acc_r <= r_acc_r + w_res_ext;
            end
        end
    end

`ifdef MIX_PEAK_EN
    logic [OUT_W-1:0] r_peak_l;
    logic [OUT_W-1:0] r_peak_r;
    logic [OUT_W-1:0] w_abs_l;
    logic [OUT_W-1:0] w_abs_r;

    // Magnitude as unsigned; the most negative value maps to 2^(OUT_W-1)
    function automatic logic [OUT_W-1:0] f_abs(input logic [OUT_W-1:0] a);
        if (a[OUT_W-1]) begin
            return (~a) + OUT_W'(1);
        end else begin
            return a;
        end
    endfunction

    assign w_abs_l = f_abs(r_audio_l);
    assign w_abs_r = f_abs(r_audio_r);

    // Peak-hold capture on each new sample; a clear overrides a capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end else if (peak_clr) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end else if (r_sample_valid) begin
            if (w_abs_l > r_peak_l) r_peak_l <= w_abs_l;
            if (w_abs_r > r_peak_r) r_peak_r <= w_abs_r;
        end
    end

    assign peak_l = r_peak_l;
    assign peak_r = r_peak_r;
`else
    logic w_unused_peak_clr;

    assign w_unused_peak_clr = peak_clr;
    assign peak_l            = '0;
    assign peak_r            = '0;
`endif

endmodule
`default_nettype wire
